// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: sequencer state
// encoding and the default reset / trap-vector addresses.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

    localparam logic [31:0] PC_DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_DEF_TRAP_VEC = 32'h0000_0100;
    localparam int          PC_DEF_INC      = 4;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select for pc_sequencer.
// Priority: trap > mret > redirect > sequential advance > hold.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned redirect becomes a trap
// and reports the offending target through o_bad_we).
module pc_next_mux #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   TRAP_VEC = XLEN'(pc_pkg::PC_DEF_TRAP_VEC)
) (
    input  logic            i_run,
    input  logic            i_trap,
    input  logic            i_mret,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_accept,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus,
    input  logic [XLEN-1:0] i_epc,
`ifdef MISALIGN_TRAP_EN
    output logic            o_bad_we,
`endif
    output logic [XLEN-1:0] o_pc_next,
    output logic            o_pc_we,
    output logic            o_epc_we
);

    // Word-aligned view of the redirect target (low two bits cleared).
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] w_target_aligned;
    assign w_target_aligned = i_target & ALIGN_MASK;

    // Priority select of the next PC; nothing changes outside RUN.
    always_comb begin
        o_pc_next = i_pc;
        o_pc_we   = 1'b0;
        o_epc_we  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        o_bad_we  = 1'b0;
`endif
        if (i_run) begin
            if (i_trap) begin
                o_pc_next = TRAP_VEC;
                o_pc_we   = 1'b1;
                o_epc_we  = 1'b1;
            end else if (i_mret) begin
                o_pc_next = i_epc;
                o_pc_we   = 1'b1;
            end else if (i_redirect) begin
`ifdef MISALIGN_TRAP_EN
                if (i_target[1:0] != 2'b00) begin
                    o_pc_next = TRAP_VEC;
                    o_pc_we   = 1'b1;
                    o_epc_we  = 1'b1;
                    o_bad_we  = 1'b1;
                end else begin
                    o_pc_next = w_target_aligned;
                    o_pc_we   = 1'b1;
                end
`else
                o_pc_next = w_target_aligned;
                o_pc_we   = 1'b1;
`endif
            end else if (i_accept) begin
                o_pc_next = i_pc_plus;
                o_pc_we   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the RV32IM core. Issues fetch addresses over
// a valid/ready handshake and handles stall, redirect, trap/mret and debug
// halt/resume. BOOT lasts one cycle after reset release, then RUN.
// Optional feature macro: MISALIGN_TRAP_EN (adds badaddr_o; a misaligned
// redirect traps instead of being silently aligned).
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(PC_DEF_RESET_PC),
    parameter int              INC      = PC_DEF_INC,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(PC_DEF_TRAP_VEC),
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fetch_valid_o,
    input  logic             fetch_ready_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus_o,
    input  logic             stall_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_target_i,
    input  logic             trap_i,
    input  logic             mret_i,
    output logic [XLEN-1:0]  epc_o,
    input  logic             halt_i,
    input  logic             resume_i,
    output logic             halted_o,
`ifdef MISALIGN_TRAP_EN
    output logic [XLEN-1:0]  badaddr_o,
`endif
    output logic [CNT_W-1:0] fetch_count_o
);

    pc_state_e        r_state;
    pc_state_e        w_state_next;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_epc;
    logic [CNT_W-1:0] r_cnt;
    logic             w_fetch_valid;
    logic             w_halted;
    logic             w_run;
    logic             w_accept;
    logic [XLEN-1:0]  w_pc_plus;
    logic [XLEN-1:0]  w_pc_next;
    logic             w_pc_we;
    logic             w_epc_we;
`ifdef MISALIGN_TRAP_EN
    logic             w_bad_we;
    logic [XLEN-1:0]  r_badaddr;
`endif

    assign w_run     = (r_state == ST_RUN);
    assign w_accept  = w_fetch_valid & fetch_ready_i & ~stall_i;
    // Sequential successor, wraps modulo 2^XLEN.
    assign w_pc_plus = r_pc + XLEN'(INC);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: halt is ignored in BOOT, resume wins over halt in HALTED.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT:   w_state_next = ST_RUN;
            ST_RUN:    if (halt_i)   w_state_next = ST_HALTED;
            ST_HALTED: if (resume_i) w_state_next = ST_RUN;
            default:   w_state_next = ST_BOOT;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_fetch_valid = (r_state == ST_RUN);
        w_halted      = (r_state == ST_HALTED);
    end

    pc_next_mux #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_next_mux (
        .i_run      (w_run),
        .i_trap     (trap_i),
        .i_mret     (mret_i),
        .i_redirect (redirect_valid_i),
        .i_target   (redirect_target_i),
        .i_accept   (w_accept),
        .i_pc       (r_pc),
        .i_pc_plus  (w_pc_plus),
        .i_epc      (r_epc),
`ifdef MISALIGN_TRAP_EN
        .o_bad_we   (w_bad_we),
`endif
        .o_pc_next  (w_pc_next),
        .o_pc_we    (w_pc_we),
        .o_epc_we   (w_epc_we)
    );

    // Fetch PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (w_pc_we) begin
            r_pc <= w_pc_next;
        end
    end

    // Exception PC captures the PC that was current when the trap was taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epc <= '0;
        end else if (w_epc_we) begin
            r_epc <= r_pc;
        end
    end

    // Accepted-fetch counter; counts even when a redirect/trap overrides the PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Faulting redirect target, held until the next misaligned redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_badaddr <= '0;
        end else if (w_bad_we) begin
            r_badaddr <= redirect_target_i;
        end
    end

    assign badaddr_o = r_badaddr;
`endif

    assign fetch_valid_o = w_fetch_valid;
    assign halted_o      = w_halted;
    assign pc_o          = r_pc;
    assign pc_plus_o     = w_pc_plus;
    assign epc_o         = r_epc;
    assign fetch_count_o = r_cnt;

endmodule
